// File: rtl/uart_frame_parser.sv
// uart_frame_parser: pops RX FIFO bytes and parses AA 55 CMD LEN PAYLOAD CHK frames into payload strobes and ok/err results.
module uart_frame_parser #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  output logic [7:0] cmd,
  output logic [7:0] len,
  output logic [7:0] pay_data,
  output logic       pay_valid,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);
  localparam int CW = $clog2(TIMEOUT) > 17 ? $clog2(TIMEOUT) : 17;
  localparam logic [7:0] ML = 8'(MAX_LEN);
  // counter reads k-1 on the k-th idle cycle, so this fires the error TIMEOUT cycles after the last byte strobe
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 2);
  typedef enum logic [2:0] {HDR0, HDR1, CMD, LEN, PAY, CHK} state_t;
  state_t state, state_n;
  logic byte_vld, ok_n, err_n, timed_out, idle;
  logic [1:0] code_n;
  logic [7:0] sum, rem;
  logic [CW-1:0] cnt;
  assign fifo_rd_en = !fifo_empty && !rst;
  assign idle = state == HDR0 || state == HDR1;
  assign timed_out = !byte_vld && !idle && cnt == TLIM;
  always_comb begin
    state_n = state;
    ok_n = 1'b0;
    err_n = 1'b0;
    code_n = err_code;
    if (byte_vld)
      case (state)
        HDR0: state_n = fifo_dout == 8'hAA ? HDR1 : HDR0;
        HDR1: state_n = fifo_dout == 8'h55 ? CMD : fifo_dout == 8'hAA ? HDR1 : HDR0;
        CMD:  state_n = LEN;
        LEN: begin
          err_n = fifo_dout > ML;
          code_n = err_n ? 2'd2 : err_code;
          state_n = err_n ? HDR0 : fifo_dout == 8'd0 ? CHK : PAY;
        end
        PAY:  state_n = rem == 8'd1 ? CHK : PAY;
        default: begin
          ok_n = fifo_dout == sum;
          err_n = !ok_n;
          code_n = ok_n ? err_code : 2'd1;
          state_n = HDR0;
        end
      endcase
    else if (timed_out) begin
      err_n = 1'b1;
      code_n = 2'd3;
      state_n = HDR0;
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= HDR0;
      byte_vld <= 1'b0;
      cmd <= '0;
      len <= '0;
      pay_data <= '0;
      pay_valid <= 1'b0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      err_code <= '0;
      sum <= '0;
      rem <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      byte_vld <= fifo_rd_en;
      frame_ok <= ok_n;
      frame_err <= err_n;
      err_code <= code_n;
      pay_valid <= byte_vld && state == PAY;
      cnt <= (byte_vld || timed_out || idle) ? '0 : cnt + 1'b1;
      if (byte_vld && state == CMD) begin
        cmd <= fifo_dout;
        sum <= fifo_dout;
      end
      if (byte_vld && state == LEN) begin
        len <= fifo_dout;
        sum <= sum + fifo_dout;
        rem <= fifo_dout;
      end
      if (byte_vld && state == PAY) begin
        pay_data <= fifo_dout;
        sum <= sum + fifo_dout;
        rem <= rem - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: randomized FIFO feeder with a frame-level scoreboard and a decoupled output monitor.
module tb_uart_frame_parser;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 20;
  logic clk_in = 0, rst = 1, fifo_empty = 1;
  logic fifo_rd_en, pay_valid, frame_ok, frame_err;
  logic [7:0] fifo_dout = 0, cmd, len, pay_data;
  logic [1:0] err_code;
  typedef struct {int kind; int a; int b;} ev_t;
  ev_t sb[$];
  ev_t mon_e;
  logic [7:0] q[$];
  logic [7:0] pl[$];
  int checks = 0, failures = 0, cyc = 0, pop_cyc = 0, pay_cyc = 0, ok_cyc = 0, err_cyc = 0;
  int mode = 0, exp_code = 0;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .cmd(cmd), .len(len), .pay_data(pay_data),
    .pay_valid(pay_valid), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input int a, input int b);
    ev_t e;
    e.kind = k;
    e.a = a;
    e.b = b;
    sb.push_back(e);
  endtask

  task automatic put(input int b);
    q.push_back(8'(b));
  endtask

  task automatic fill(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  // Whole-frame reference: expected events follow directly from the frame's bytes.
  task automatic frame(input int c, input int n, input bit bad);
    logic [7:0] s;
    put(8'hAA);
    put(8'h55);
    put(c);
    put(n);
    s = 8'(c + n);
    if (n > MAX_LEN) begin
      expect_ev(2, 2, 0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      put(pl[i]);
      s += pl[i];
      expect_ev(0, pl[i], 0);
    end
    put(bad ? int'(s) + int'($urandom_range(1, 255)) : int'(s));
    if (bad) expect_ev(2, 1, 0);
    else expect_ev(1, c, n);
  endtask

  task automatic drain(input int extra);
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(posedge clk_in);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    repeat (extra) @(posedge clk_in);
    check("sb_empty", sb.size(), 0);
  endtask

  initial forever begin
    @(posedge clk_in);
    cyc++;
    if (fifo_rd_en) begin
      pop_cyc = cyc;
      #1 fifo_dout = q.pop_front();
    end else #1;
    fifo_empty = q.size() == 0 || (mode == 1 && cyc[0]) || (mode == 2 && $urandom_range(0, 1) == 1);
  end

  initial forever begin
    @(negedge clk_in);
    if (fifo_empty || rst) check("rd_en_gated", fifo_rd_en, 0);
    if (int'(pay_valid) + int'(frame_ok) + int'(frame_err) > 1)
      check("strobe_excl", int'(pay_valid) + int'(frame_ok) + int'(frame_err), 1);
    if (pay_valid || frame_ok || frame_err) begin
      if (sb.size() == 0) check("unexpected_strobe", {pay_valid, frame_ok, frame_err}, 0);
      else begin
        mon_e = sb.pop_front();
        check("kind", pay_valid ? 0 : frame_ok ? 1 : 2, mon_e.kind);
        if (pay_valid) begin
          check("pay_data", pay_data, mon_e.a);
          pay_cyc = cyc;
        end else if (frame_ok) begin
          check("ok_cmd", cmd, mon_e.a);
          check("ok_len", len, mon_e.b);
          check("ok_code_held", err_code, exp_code);
          ok_cyc = cyc;
        end else begin
          check("err_code", err_code, mon_e.a);
          exp_code = mon_e.a;
          err_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    put(8'h12);
    repeat (3) @(posedge clk_in);
    #2;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_cmd", cmd, 0);
    check("rst_len", len, 0);
    check("rst_pay_data", pay_data, 0);
    check("rst_err_code", err_code, 0);
    check("rst_strobes", {pay_valid, frame_ok, frame_err}, 0);
    rst = 0;
    // good frame, back-to-back
    foreach (pl[i]) pl[i] = 0;
    put(8'hAA); put(8'h55); put(8'h01); put(8'h03); put(8'h10); put(8'h20); put(8'h30); put(8'h64);
    expect_ev(0, 8'h10, 0); expect_ev(0, 8'h20, 0); expect_ev(0, 8'h30, 0); expect_ev(1, 1, 3);
    drain(4);
    check("ok_after_last_pay", ok_cyc - pay_cyc, 1);
    // bad checksum
    put(8'hAA); put(8'h55); put(8'h01); put(8'h03); put(8'h10); put(8'h20); put(8'h30); put(8'h65);
    expect_ev(0, 8'h10, 0); expect_ev(0, 8'h20, 0); expect_ev(0, 8'h30, 0); expect_ev(2, 1, 0);
    drain(4);
    // junk, resync and zero length
    put(8'h12); put(8'hAA); put(8'h34);
    put(8'hAA); put(8'hAA); put(8'h55); put(8'h07); put(8'h00); put(8'h07);
    expect_ev(1, 7, 0);
    drain(4);
    // length error, then a frame parsed from HDR0
    put(8'hAA); put(8'h55); put(8'h02); put(8'h11);
    put(8'hAA); put(8'h55); put(8'h03); put(8'h01); put(8'h05); put(8'h09);
    expect_ev(2, 2, 0); expect_ev(0, 5, 0); expect_ev(1, 3, 1);
    drain(4);
    // timeout
    put(8'hAA); put(8'h55); put(8'h01); put(8'h02); put(8'h10);
    expect_ev(0, 8'h10, 0); expect_ev(2, 3, 0);
    drain(TIMEOUT + 4);
    check("pay_latency", pay_cyc - pop_cyc, 1);
    check("timeout_latency", err_cyc - pop_cyc, TIMEOUT);
    fill(2);
    frame(5, 2, 0);
    drain(4);
    // LEN boundaries
    fill(MAX_LEN);
    frame(9, MAX_LEN, 0);
    frame(9, MAX_LEN + 1, 0);
    drain(4);
    // reset mid-frame
    put(8'hAA); put(8'h55); put(8'h01); put(8'h05); put(8'h10); put(8'h20);
    expect_ev(0, 8'h10, 0); expect_ev(0, 8'h20, 0);
    drain(4);
    @(posedge clk_in);
    #2 rst = 1;
    exp_code = 0;
    @(posedge clk_in);
    #2 rst = 0;
    check("midrst_cmd", cmd, 0);
    check("midrst_len", len, 0);
    mode = 1;
    fill(4);
    frame(8'h21, 4, 0);
    drain(8);
    // randomized frames with junk and gaps
    for (int f = 0; f < 40; f++) begin
      int n, j;
      mode = $urandom_range(0, 2);
      j = $urandom_range(0, 3);
      for (int k = 0; k < j; k++) begin
        int b;
        b = $urandom_range(0, 255);
        put(b == 8'hAA ? 8'h12 : b);
      end
      n = $urandom_range(0, MAX_LEN + 2);
      fill(n);
      frame($urandom_range(0, 255), n, $urandom_range(0, 3) == 0);
    end
    drain(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
